// File: rtl/uart_transmit.sv
`default_nettype none
// ============================================================================
// Module   : uart_transmit
// Purpose  : Serialises one byte per valid/ready handshake into an 8N1 UART
//            frame: start bit (0), data LSB first, optional even parity,
//            stop bit (1). Partner of uart_receive (same CLK_SPEED/BAUD_RATE).
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   CLK_SPEED  clock frequency in Hz
//   BAUD_RATE  line rate in bit/s
//   BAUD_TICK  (local) CLK_SPEED/BAUD_RATE clock cycles per bit, must be >= 2
//   CNT_WIDTH  (local) width of the baud counter
// Ports
//   clock     in   1  rising-edge clock for every register
//   reset     in   1  synchronous, active-high reset
//   data_in   in   8  byte to send, sampled only on the accept edge
//   in_valid  in   1  source presents a byte on data_in
//   in_ready  out  1  block can accept a byte (high only in IDLE)
//   tx        out  1  serial line, idles high, registered
//   busy      out  1  a frame is in progress (~in_ready)
//   done      out  1  one-cycle pulse in the last cycle of the stop bit
// Configuration
//   UART_TX_PARITY_EN  when defined, an even-parity bit is sent between the
//                      last data bit and the stop bit (11-bit frame).
// ============================================================================
module uart_transmit #(
  parameter int CLK_SPEED = 5_000_000,
  parameter int BAUD_RATE = 9600
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int BAUD_TICK = CLK_SPEED / BAUD_RATE;
  localparam int CNT_WIDTH = $clog2(BAUD_TICK);
  localparam logic [CNT_WIDTH-1:0] LAST_CNT     = CNT_WIDTH'(BAUD_TICK - 1);
  // done is a flop, so it is loaded one cycle ahead of the final stop cycle.
  localparam logic [CNT_WIDTH-1:0] PRE_LAST_CNT = CNT_WIDTH'(BAUD_TICK - 2);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;
`endif

  state_t               state;
  logic [CNT_WIDTH-1:0] count;
  logic [2:0]           bit_cnt;
  logic [7:0]           shreg;
  logic                 bit_end;
`ifdef UART_TX_PARITY_EN
  // Parity is captured at accept time because the shift register is
  // consumed while the data bits go out.
  logic                 parity;
`endif

  assign bit_end = (count == LAST_CNT);

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      tx       <= 1'b1;
      in_ready <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      count    <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
`ifdef UART_TX_PARITY_EN
      parity   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;

      // Baud counter runs in every non-IDLE state and wraps on bit_end.
      if (state != IDLE) begin
        count <= bit_end ? '0 : count + 1'b1;
      end

      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            shreg    <= data_in;
            count    <= '0;
            tx       <= 1'b0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= START;
`ifdef UART_TX_PARITY_EN
            parity   <= ^data_in;
`endif
          end
        end

        START: begin
          if (bit_end) begin
            tx    <= shreg[0];
            state <= DATA;
          end
        end

        DATA: begin
          if (bit_end) begin
            shreg   <= shreg >> 1;
            bit_cnt <= bit_cnt + 3'd1;  // wraps 7 -> 0 after the last bit
            if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              tx    <= parity;
              state <= PARITY;
`else
              tx    <= 1'b1;
              state <= STOP;
`endif
            end else begin
              // shreg[1] becomes shreg[0] after this shift.
              tx <= shreg[1];
            end
          end
        end

`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            tx    <= 1'b1;
            state <= STOP;
          end
        end
`endif

        STOP: begin
          if (count == PRE_LAST_CNT) begin
            done <= 1'b1;
          end
          if (bit_end) begin
            in_ready <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end
        end

        default: begin
          tx       <= 1'b1;
          in_ready <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_transmit.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_transmit
// Purpose  : Self-checking bench for uart_transmit (CLK_SPEED=16,
//            BAUD_RATE=1, so 16 cycles per bit). Expected line levels come
//            from a frame-bit list built from the byte value.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_transmit;

  localparam int BT = 16;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * BT;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic       in_valid;
  logic       in_ready;
  logic       tx;
  logic       busy;
  logic       done;

  int checks   = 0;
  int failures = 0;

  uart_transmit #(
    .CLK_SPEED (16),
    .BAUD_RATE (1)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .data_in  (data_in),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .tx       (tx),
    .busy     (busy),
    .done     (done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Line level expected in each bit slot of a frame carrying d.
  function automatic void build_frame(input logic [7:0] d, output logic bits [NBITS]);
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i + 1] = d[i];
`ifdef UART_TX_PARITY_EN
    bits[9] = ^d;
`endif
    bits[NBITS - 1] = 1'b1;
  endfunction

  task automatic idle_check(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      chk({tag, "_tx"},    tx,       1);
      chk({tag, "_ready"}, in_ready, 1);
      chk({tag, "_busy"},  busy,     0);
      chk({tag, "_done"},  done,     0);
    end
  endtask

  // Called right after the accept edge. Checks every cycle of the frame and
  // the first IDLE cycle. keep: hold in_valid high with next_d afterwards.
  // scramble: wiggle data_in/in_valid during the frame. abort_at: cycle at
  // which reset is raised (0 = never).
  task automatic run_frame(input logic [7:0] d, input bit keep, input logic [7:0] next_d,
                           input bit scramble, input int abort_at, input string tag);
    logic bits [NBITS];
    build_frame(d, bits);
    for (int j = 1; j <= FRAME + 1; j++) begin
      @(negedge clock);
      if (j <= FRAME) begin
        chk({tag, "_tx"},    tx,       bits[(j - 1) / BT]);
        chk({tag, "_done"},  done,     (j == FRAME) ? 1 : 0);
        chk({tag, "_ready"}, in_ready, 0);
        chk({tag, "_busy"},  busy,     1);
      end else begin
        chk({tag, "_gap_tx"},    tx,       1);
        chk({tag, "_end_ready"}, in_ready, 1);
        chk({tag, "_end_busy"},  busy,     0);
        chk({tag, "_end_done"},  done,     0);
      end
      if (abort_at != 0 && j == abort_at) begin
        reset    = 1'b1;
        in_valid = 1'b0;
        @(negedge clock);
        chk({tag, "_rst_tx"},    tx,       1);
        chk({tag, "_rst_ready"}, in_ready, 1);
        chk({tag, "_rst_busy"},  busy,     0);
        chk({tag, "_rst_done"},  done,     0);
        reset = 1'b0;
        return;
      end
      if (keep) begin
        in_valid = 1'b1;
        data_in  = next_d;
      end else if (scramble && j < FRAME - 1) begin
        data_in  = 8'($urandom);
        in_valid = 1'($urandom);
      end else begin
        in_valid = 1'b0;
      end
    end
  endtask

  // Called just after a negedge while the DUT is idle.
  task automatic send(input logic [7:0] d, input bit keep, input logic [7:0] next_d,
                      input bit scramble, input int abort_at, input string tag);
    data_in  = d;
    in_valid = 1'b1;
    @(posedge clock);
    run_frame(d, keep, next_d, scramble, abort_at, tag);
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    data_in  = 8'h00;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("reset_tx",    tx,       1);
    chk("reset_ready", in_ready, 1);
    chk("reset_busy",  busy,     0);
    chk("reset_done",  done,     0);
    reset = 1'b0;
    idle_check(20, "idle");

    // Directed byte.
    send(8'hA5, 1'b0, 8'h00, 1'b0, 0, "a5");
    idle_check(3, "post_a5");

    // Parity-one pattern (also a plain frame without parity).
    send(8'h07, 1'b0, 8'h00, 1'b0, 0, "b07");
    idle_check(2, "post_07");

    // Back-to-back with in_valid held high: second accept on first IDLE cycle.
    send(8'h00, 1'b1, 8'hFF, 1'b0, 0, "b2b0");
    send(8'hFF, 1'b0, 8'h00, 1'b0, 0, "b2b1");
    idle_check(3, "post_b2b");

    // Mid-frame input noise must not alter the frame or spawn another one.
    send(8'h3C, 1'b0, 8'h00, 1'b1, 0, "noise");
    idle_check(20, "post_noise");

    // Reset during data bit 3 (cycles 65..80 after accept).
    send(8'hF0, 1'b0, 8'h00, 1'b0, 70, "abort");
    idle_check(BT * NBITS + 5, "post_abort");

    // Randomised bytes with random idle gaps and occasional noise.
    for (int k = 0; k < 8; k++) begin
      logic [7:0] rb;
      rb = 8'($urandom);
      idle_check(int'($urandom_range(0, 4)), "rnd_gap");
      send(rb, 1'b0, 8'h00, 1'($urandom), 0, "rnd");
    end
    idle_check(5, "final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
